sram_sync: RTL and testbench

SRAM_SYNC -- requirements
Module: sram_sync

---
 rtl/sram_pkg.sv | 14 +
 rtl/sram_array.sv | 56 +++++
 rtl/sram_sync.sv | 146 ++++++++++++++
 tb/tb_sram_sync.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the synchronous SRAM block.
//   state_e  : controller state (StInit clears the array, StIdle serves requests)
//   RdLatMin / RdLatMax : legal range of the read-latency parameter
package sram_pkg;

  typedef enum logic {
    StInit = 1'b0,
    StIdle = 1'b1
  } state_e;

  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 3;

endpackage

// File: rtl/sram_array.sv
// Storage array: byte-enabled synchronous write, registered read.
// Ports:
//   clk, rst       : clock, async active-high reset (read register only)
//   i_we, i_waddr, i_wdata, i_wbe : write port, bit i of i_wbe gates byte i
//   i_re, i_raddr  : read port; o_rdata loads on i_re and holds otherwise
// WR_FIRST != 0 returns the merged new word when a read and write hit the
// same address in the same cycle; otherwise the old word is returned.
module sram_array #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned WR_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wbe,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  output logic [DW-1:0]   o_rdata
);

  localparam int unsigned NB = DW / 8;

  // Contents are deliberately not reset; the controller clears them.
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] w_rd_word;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (i_we && i_wbe[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  always_comb begin
    w_rd_word = r_mem[i_raddr];
    if ((WR_FIRST != 0) && i_we && (i_waddr == i_raddr)) begin
      for (int i = 0; i < NB; i++) begin
        if (i_wbe[i]) w_rd_word[8*i +: 8] = i_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_rd_word;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_sync.sv
// Synchronous SRAM controller: init/clear sweep, request acceptance, error
// reporting and the read-latency pipeline around sram_array.
// Ports:
//   clk, rst        : clock, async active-high reset
//   cs, wr, rd      : chip select and single-cycle requests (rd ^ wr is legal)
//   addr, din, be   : word address, write data, byte enables
//   clr             : pulse to re-clear the whole array
//   ready           : high in IDLE, i.e. when a request is accepted this cycle
//   dout/dout_valid : read data (holds between reads) and its 1-cycle strobe
//   err             : 1-cycle pulse after an illegal or dropped request
module sram_sync
  import sram_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WR_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic            wr,
  input  logic            rd,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   din,
  input  logic [DW/8-1:0] be,
  input  logic            clr,
  output logic            ready,
  output logic [DW-1:0]   dout,
  output logic            dout_valid,
  output logic            err
);

  if ((RD_LAT < RdLatMin) || (RD_LAT > RdLatMax)) begin : g_bad_rd_lat
    $error("sram_sync: RD_LAT out of range");
  end
  if ((DW % 8) != 0) begin : g_bad_dw
    $error("sram_sync: DW must be a multiple of 8");
  end

  state_e                    r_state, w_state_next;
  logic [AW-1:0]             r_clr_addr, w_clr_addr_next;
  logic                      w_req, w_acc_rd, w_acc_wr;
  logic                      r_err;
  logic [RD_LAT-1:0]         r_vld;
  logic [RD_LAT-1:0][DW-1:0] w_stage;

  logic                      w_arr_we;
  logic [AW-1:0]             w_arr_waddr;
  logic [DW-1:0]             w_arr_wdata;
  logic [DW/8-1:0]           w_arr_wbe;
  logic [DW-1:0]             w_arr_rdata;

  assign ready    = (r_state == StIdle);
  assign w_req    = cs && (rd || wr);
  assign w_acc_rd = cs && ready && rd && !wr;
  assign w_acc_wr = cs && ready && wr && !rd;

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    unique case (r_state)
      StInit: begin
        if (clr) begin
          w_clr_addr_next = '0;
        end else if (&r_clr_addr) begin
          w_state_next    = StIdle;
          w_clr_addr_next = '0;
        end else begin
          w_clr_addr_next = r_clr_addr + 1'b1;
        end
      end
      StIdle: begin
        // Reads already accepted keep flowing through the pipeline.
        if (clr) begin
          w_state_next    = StInit;
          w_clr_addr_next = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StInit;
      r_clr_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
      r_err      <= w_req && (!ready || (rd && wr));
    end
  end

  // The sweep owns the write port in INIT; no user write is accepted then.
  // A write lands at its accepting edge, so a read one cycle later already
  // sees it in the array for every RD_LAT.
  assign w_arr_we    = ready ? w_acc_wr : 1'b1;
  assign w_arr_waddr = ready ? addr : r_clr_addr;
  assign w_arr_wdata = ready ? din : '0;
  assign w_arr_wbe   = ready ? be : '1;

  sram_array #(
    .DW       (DW),
    .AW       (AW),
    .WR_FIRST (WR_FIRST)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_wbe   (w_arr_wbe),
    .i_re    (w_acc_rd),
    .i_raddr (addr),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_acc_rd;
      for (int s = 1; s < RD_LAT; s++) r_vld[s] <= r_vld[s-1];
    end
  end

  // Each stage loads only with a valid word, so the last stage holds dout.
  assign w_stage[0] = w_arr_rdata;
  for (genvar s = 1; s < RD_LAT; s++) begin : g_pipe
    logic [DW-1:0] r_data;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= '0;
      end else if (r_vld[s-1]) begin
        r_data <= w_stage[s-1];
      end
    end
    assign w_stage[s] = r_data;
  end

  assign dout       = w_stage[RD_LAT-1];
  assign dout_valid = r_vld[RD_LAT-1];
  assign err        = r_err;

endmodule

// File: tb/tb_sram_sync.sv
// Bench for sram_sync: three instances (RD_LAT 1, 2, 3; DW=16, AW=8) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_sram_sync;

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [1:0]  be;
    logic        clr;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  logic        clk, rst, cs, rd, wr, clr;
  logic [7:0]  addr;
  logic [15:0] din;
  logic [1:0]  be;

  logic [15:0] dout_o  [1:3];
  logic        dv_o    [1:3];
  logic        rdy_o   [1:3];
  logic        err_o   [1:3];

  sram_sync #(.DW(16), .AW(8), .RD_LAT(1), .WR_FIRST(0)) u_dut1 (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din), .be(be),
    .clr(clr), .ready(rdy_o[1]), .dout(dout_o[1]), .dout_valid(dv_o[1]), .err(err_o[1])
  );
  sram_sync #(.DW(16), .AW(8), .RD_LAT(2), .WR_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din), .be(be),
    .clr(clr), .ready(rdy_o[2]), .dout(dout_o[2]), .dout_valid(dv_o[2]), .err(err_o[2])
  );
  sram_sync #(.DW(16), .AW(8), .RD_LAT(3), .WR_FIRST(0)) u_dut3 (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din), .be(be),
    .clr(clr), .ready(rdy_o[3]), .dout(dout_o[3]), .dout_valid(dv_o[3]), .err(err_o[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: memory image, clear cycles remaining, recent accepted reads.
  logic [15:0] mem_m [256];
  int          rem;
  logic        hist_v [3];
  logic [15:0] hist_d [3];
  logic [15:0] exp_dout [1:3];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_n    = 0;

  function automatic vec_t mk(input logic c, input logic r, input logic w, input logic [7:0] a,
                              input logic [15:0] d, input logic [1:0] b, input logic cl,
                              input logic e_err, input logic [15:0] e_data);
    vec_t v;
    v.cs = c; v.rd = r; v.wr = w; v.addr = a; v.din = d; v.be = b; v.clr = cl;
    v.exp_err = e_err; v.exp_rdata = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input int l, input logic [15:0] act,
                     input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s lat=%0d cycle=%0d actual=%h required=%h", name, l, cyc_n, act, req);
    end
  endtask

  task automatic model_reset();
    rem = 256;
    for (int i = 0; i < 3; i++) begin hist_v[i] = 1'b0; hist_d[i] = '0; end
    for (int l = 1; l <= 3; l++) exp_dout[l] = '0;
    for (int a = 0; a < 256; a++) mem_m[a] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 0; rd = 0; wr = 0; clr = 0; addr = '0; din = '0; be = '0;
    #1;
    for (int l = 1; l <= 3; l++) begin
      chk("rst_dout", l, dout_o[l], 16'h0);
      chk("rst_valid", l, 16'(dv_o[l]), 16'h0);
      chk("rst_err", l, 16'(err_o[l]), 16'h0);
      chk("rst_ready", l, 16'(rdy_o[l]), 16'h0);
    end
    repeat (2) begin
      @(posedge clk); #1;
      for (int l = 1; l <= 3; l++) chk("rst_hold_valid", l, 16'(dv_o[l]), 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive v, advance the model across the edge, compare all DUTs.
  task automatic cyc(input vec_t v, input bit use_tab);
    bit          rdy_m, acc_rd, acc_wr, err_m;
    logic [15:0] rdat;
    rdy_m  = (rem == 0);
    acc_rd = v.cs && rdy_m && v.rd && !v.wr;
    acc_wr = v.cs && rdy_m && v.wr && !v.rd;
    err_m  = v.cs && (v.rd || v.wr) && (!rdy_m || (v.rd && v.wr));
    rdat   = mem_m[v.addr];
    cs = v.cs; rd = v.rd; wr = v.wr; addr = v.addr; din = v.din; be = v.be; clr = v.clr;
    @(posedge clk);
    cyc_n++;
    if (acc_wr) begin
      for (int i = 0; i < 2; i++) if (v.be[i]) mem_m[v.addr][8*i +: 8] = v.din[8*i +: 8];
    end
    if (v.clr) begin
      for (int a = 0; a < 256; a++) mem_m[a] = '0;
      rem = 256;
    end else if (rem != 0) begin
      rem--;
    end
    hist_v[2] = hist_v[1]; hist_d[2] = hist_d[1];
    hist_v[1] = hist_v[0]; hist_d[1] = hist_d[0];
    hist_v[0] = acc_rd;    hist_d[0] = use_tab ? v.exp_rdata : rdat;
    #1;
    for (int l = 1; l <= 3; l++) begin
      chk("ready", l, 16'(rdy_o[l]), 16'(rem == 0));
      chk("err", l, 16'(err_o[l]), 16'(use_tab ? v.exp_err : err_m));
      chk("dout_valid", l, 16'(dv_o[l]), 16'(hist_v[l-1]));
      if (hist_v[l-1]) exp_dout[l] = hist_d[l-1];
      chk("dout", l, dout_o[l], exp_dout[l]);
    end
  endtask

  vec_t tab[$];
  vec_t idle;
  vec_t rv;

  initial begin
    idle = mk(0, 0, 0, 8'h00, 16'h0, 2'b00, 0, 0, 16'h0);

    // Directed vectors, applied once the first sweep has finished.
    tab.push_back(mk(1, 1, 0, 8'h5A, 16'h0000, 2'b00, 0, 0, 16'h0000));
    tab.push_back(mk(1, 0, 1, 8'h10, 16'h00A5, 2'b11, 0, 0, 16'h0000));
    tab.push_back(mk(1, 1, 0, 8'h10, 16'h0000, 2'b00, 0, 0, 16'h00A5));
    tab.push_back(mk(1, 0, 1, 8'h03, 16'h1234, 2'b11, 0, 0, 16'h0000));
    tab.push_back(mk(1, 0, 1, 8'h03, 16'hFFFF, 2'b01, 0, 0, 16'h0000));
    tab.push_back(mk(1, 1, 0, 8'h03, 16'h0000, 2'b00, 0, 0, 16'h12FF));
    tab.push_back(mk(1, 0, 1, 8'h20, 16'hBEEF, 2'b11, 0, 0, 16'h0000));
    tab.push_back(mk(1, 1, 1, 8'h20, 16'h0000, 2'b11, 0, 1, 16'h0000));
    tab.push_back(mk(1, 1, 0, 8'h20, 16'h0000, 2'b00, 0, 0, 16'hBEEF));
    tab.push_back(mk(1, 0, 1, 8'h03, 16'h0000, 2'b00, 0, 0, 16'h0000));
    tab.push_back(mk(1, 1, 0, 8'h03, 16'h0000, 2'b00, 0, 0, 16'h12FF));
    tab.push_back(mk(0, 1, 0, 8'h03, 16'h0000, 2'b00, 0, 0, 16'h0000));
    for (int a = 0; a < 8; a++)
      tab.push_back(mk(1, 0, 1, 8'(a), 16'h0101 * 16'(a + 1), 2'b11, 0, 0, 16'h0));
    // Burst of reads; clr arrives with the read of 0x04, later reads are dropped.
    for (int a = 0; a < 8; a++)
      tab.push_back(mk(1, 1, 0, 8'(a), 16'h0, 2'b00, (a == 4) ? 1'b1 : 1'b0,
                       (a > 4) ? 1'b1 : 1'b0, 16'h0101 * 16'(a + 1)));

    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 10) cyc(mk(1, 1, 0, 8'h00, 16'h0, 2'b00, 0, 0, 16'h0), 1'b0);
      else cyc(idle, 1'b0);
    end

    foreach (tab[i]) cyc(tab[i], 1'b1);

    // Remaining clear cycles after the mid-burst clr; ready is checked each one.
    for (int i = 0; i < 260 && rem != 0; i++) cyc(idle, 1'b0);
    cyc(mk(1, 1, 0, 8'h03, 16'h0, 2'b00, 0, 0, 16'h0), 1'b0);

    for (int i = 0; i < 2500; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      rv = idle;
      rv.cs   = ($urandom_range(0, 9) != 0);
      rv.rd   = (op <= 3) || (op == 8);
      rv.wr   = (op >= 4 && op <= 8);
      rv.addr = 8'($urandom_range(0, 15));
      rv.din  = 16'($urandom);
      rv.be   = 2'($urandom_range(0, 3));
      rv.clr  = ($urandom_range(0, 599) == 0);
      cyc(rv, 1'b0);
    end

    for (int i = 0; i < 260 && rem != 0; i++) cyc(idle, 1'b0);
    cyc(mk(1, 0, 1, 8'h05, 16'hCAFE, 2'b11, 0, 0, 16'h0), 1'b0);
    cyc(mk(1, 1, 0, 8'h05, 16'h0, 2'b00, 0, 0, 16'h0), 1'b0);
    cyc(mk(1, 1, 0, 8'h05, 16'h0, 2'b00, 0, 0, 16'h0), 1'b0);
    do_reset();
    for (int i = 0; i < 258; i++) cyc(idle, 1'b0);
    cyc(mk(1, 1, 0, 8'h05, 16'h0, 2'b00, 0, 0, 16'h0), 1'b0);
    repeat (3) cyc(idle, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
